// File: rtl/ac97_pkg.sv
// ac97_pkg: slot map, tag bit positions and frame-alignment states shared by
// the AC'97 receive and transmit paths.
package ac97_pkg;
    localparam logic [7:0] TAG_END   = 8'd15;
    localparam logic [7:0] SLOT1_END = 8'd35;
    localparam logic [7:0] SLOT2_END = 8'd55;
    localparam logic [7:0] SLOT3_END = 8'd75;
    localparam logic [7:0] SLOT4_END = 8'd95;
    localparam int READY    = 15;
    localparam int VALID_S1 = 14;
    localparam int VALID_S2 = 13;
    localparam int VALID_L  = 12;
    localparam int VALID_R  = 11;
    localparam int SLOT_W   = 20;
    typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} align_state_e;
endpackage

// File: rtl/ac97_frame_aligner.sv
// ac97_frame_aligner: SYNC rise detection, frame bit counter and lock state machine.
// o_bit_idx is the frame bit index of the sample taken on the current edge.
module ac97_frame_aligner #(
    parameter int FRAME_BITS  = 256,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sync,
    output logic [7:0] o_bit_idx,
    output logic       o_decode,
    output logic       o_locked,
    output logic       o_sync_error
);
    import ac97_pkg::*;

    localparam logic [7:0] LAST = 8'(FRAME_BITS - 1);
    localparam logic [7:0] NEED = 8'(LOCK_FRAMES);

    align_state_e r_state, w_state_next;
    logic [7:0]   r_count, w_idx;
    logic [7:0]   r_good, w_good_next;
    logic         r_sync_prev, r_sync_error;
    logic         w_rise, w_wrap, w_err;

    always_comb begin
        w_rise       = i_sync && !r_sync_prev;
        w_wrap       = r_count == LAST;
        w_err        = 1'b0;
        w_idx        = (r_state == HUNT || w_wrap) ? 8'd0 : r_count + 8'd1;
        w_good_next  = r_good;
        w_state_next = r_state;
        if (r_state == HUNT) begin
            if (w_rise) begin
                w_good_next  = 8'd0;
                w_state_next = (NEED == 8'd0) ? LOCKED : ALIGN;
            end
        end else if (w_rise != w_wrap) begin
            // a rise off the wrap restarts alignment; a wrap without a rise loses it
            w_err        = 1'b1;
            w_idx        = 8'd0;
            w_good_next  = 8'd0;
            w_state_next = w_rise ? ALIGN : HUNT;
        end else if (w_rise && r_state == ALIGN) begin
            w_good_next  = r_good + 8'd1;
            w_state_next = (w_good_next >= NEED) ? LOCKED : ALIGN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= HUNT;
            r_count      <= 8'd0;
            r_good       <= 8'd0;
            r_sync_prev  <= 1'b0;
            r_sync_error <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_idx;
            r_good       <= w_good_next;
            r_sync_prev  <= i_sync;
            r_sync_error <= w_err;
        end
    end

    assign o_bit_idx    = w_idx;
    assign o_decode     = (r_state == LOCKED) && !w_err;
    assign o_locked     = r_state == LOCKED;
    assign o_sync_error = r_sync_error;
endmodule

// File: rtl/ac97_receiver.sv
// ac97_receiver: deserializes SDATA_IN into tag, status and PCM slots, committing
// each locked frame one edge after its bit 95 with single-cycle strobes.
module ac97_receiver #(
    parameter int FRAME_BITS  = 256,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        BIT_CLK,
    input  logic        SYSTEM_RESET,
    input  logic        SYNC,
    input  logic        SDATA_IN,
    output logic        LOCKED,
    output logic        SYNC_ERROR,
    output logic        CODEC_READY,
    output logic [15:0] TAG,
    output logic [19:0] STATUS_ADDR,
    output logic [19:0] STATUS_DATA,
    output logic [19:0] PCM_L,
    output logic [19:0] PCM_R,
    output logic        STATUS_VALID,
    output logic        PCM_VALID,
    output logic        FRAME_VALID
);
    import ac97_pkg::*;

    logic [7:0]        w_bit;
    logic              w_decode, w_locked, w_sync_error;
    logic [SLOT_W-1:0] w_shift;
    logic [SLOT_W-2:0] r_shift;
    logic [15:0]       r_tag_h, r_tag;
    logic [SLOT_W-1:0] r_s1_h, r_s2_h, r_s3_h, r_s4_h;
    logic [SLOT_W-1:0] r_addr, r_data, r_pcm_l, r_pcm_r;
    logic              r_commit, r_status_valid, r_pcm_valid, r_frame_valid;
    logic              w_upd_status, w_upd_l, w_upd_r;

    ac97_frame_aligner #(
        .FRAME_BITS (FRAME_BITS),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_aligner (
        .i_clk       (BIT_CLK),
        .i_rst       (SYSTEM_RESET),
        .i_sync      (SYNC),
        .o_bit_idx   (w_bit),
        .o_decode    (w_decode),
        .o_locked    (w_locked),
        .o_sync_error(w_sync_error)
    );

    assign w_shift      = {r_shift, SDATA_IN};
    assign w_upd_status = r_commit && r_tag_h[VALID_S1] && r_tag_h[VALID_S2];
    assign w_upd_l      = r_commit && r_tag_h[VALID_L];
    assign w_upd_r      = r_commit && r_tag_h[VALID_R];

    always_ff @(posedge BIT_CLK) begin
        if (SYSTEM_RESET) begin
            r_shift        <= '0;
            r_tag_h        <= '0;
            r_s1_h         <= '0;
            r_s2_h         <= '0;
            r_s3_h         <= '0;
            r_s4_h         <= '0;
            r_tag          <= '0;
            r_addr         <= '0;
            r_data         <= '0;
            r_pcm_l        <= '0;
            r_pcm_r        <= '0;
            r_commit       <= 1'b0;
            r_status_valid <= 1'b0;
            r_pcm_valid    <= 1'b0;
            r_frame_valid  <= 1'b0;
        end else begin
            r_shift <= w_shift[SLOT_W-2:0];
            if (w_bit == TAG_END)   r_tag_h <= w_shift[15:0];
            if (w_bit == SLOT1_END) r_s1_h  <= w_shift;
            if (w_bit == SLOT2_END) r_s2_h  <= w_shift;
            if (w_bit == SLOT3_END) r_s3_h  <= w_shift;
            if (w_bit == SLOT4_END) r_s4_h  <= w_shift;
            // decided on the bit-95 edge, so a later SYNC error cannot cancel it
            r_commit       <= w_decode && (w_bit == SLOT4_END);
            r_frame_valid  <= r_commit;
            r_status_valid <= w_upd_status;
            r_pcm_valid    <= w_upd_l || w_upd_r;
            if (r_commit) r_tag <= r_tag_h;
            if (w_upd_status) begin
                r_addr <= r_s1_h;
                r_data <= r_s2_h;
            end
            if (w_upd_l) r_pcm_l <= r_s3_h;
            if (w_upd_r) r_pcm_r <= r_s4_h;
        end
    end

    assign LOCKED       = w_locked;
    assign SYNC_ERROR   = w_sync_error;
    assign CODEC_READY  = r_tag[READY];
    assign TAG          = r_tag;
    assign STATUS_ADDR  = r_addr;
    assign STATUS_DATA  = r_data;
    assign PCM_L        = r_pcm_l;
    assign PCM_R        = r_pcm_r;
    assign STATUS_VALID = r_status_valid;
    assign PCM_VALID    = r_pcm_valid;
    assign FRAME_VALID  = r_frame_valid;
endmodule

// File: tb/tb_ac97_receiver.sv
// tb_ac97_receiver: directed lock/error/reset sequence with randomized frame contents,
// checked against a slot-level model of the committed outputs.
module tb_ac97_receiver;
    typedef struct packed {
        logic [15:0] tag;
        logic [19:0] s1, s2, s3, s4;
    } frame_t;
    typedef struct packed {
        logic [15:0] tag;
        logic [19:0] sa, sd, pl, pr;
    } outs_t;

    logic clk = 1'b0, rst = 1'b1, sync = 1'b0, sdata = 1'b0;
    logic locked, sync_error, codec_ready, status_valid, pcm_valid, frame_valid;
    logic [15:0] tag;
    logic [19:0] status_addr, status_data, pcm_l, pcm_r;
    int checks = 0, errors = 0;
    int n_fv = 0, n_sv = 0, n_pv = 0, n_err = 0;
    outs_t m;
    frame_t f, g;

    always #5 clk = ~clk;

    ac97_receiver #(.FRAME_BITS(256), .LOCK_FRAMES(2)) dut (
        .BIT_CLK     (clk),
        .SYSTEM_RESET(rst),
        .SYNC        (sync),
        .SDATA_IN    (sdata),
        .LOCKED      (locked),
        .SYNC_ERROR  (sync_error),
        .CODEC_READY (codec_ready),
        .TAG         (tag),
        .STATUS_ADDR (status_addr),
        .STATUS_DATA (status_data),
        .PCM_L       (pcm_l),
        .PCM_R       (pcm_r),
        .STATUS_VALID(status_valid),
        .PCM_VALID   (pcm_valid),
        .FRAME_VALID (frame_valid)
    );

    function automatic frame_t rnd_frame(input logic [4:0] flags);
        frame_t r;
        r.tag = {flags, 11'($urandom)};
        r.s1  = 20'($urandom);
        r.s2  = 20'($urandom);
        r.s3  = 20'($urandom);
        r.s4  = 20'($urandom);
        return r;
    endfunction

    function automatic outs_t apply(input outs_t o, input frame_t fr);
        outs_t n = o;
        n.tag = fr.tag;
        if (fr.tag[14] && fr.tag[13]) begin
            n.sa = fr.s1;
            n.sd = fr.s2;
        end
        if (fr.tag[12]) n.pl = fr.s3;
        if (fr.tag[11]) n.pr = fr.s4;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic d);
        sync = s;
        sdata = d;
        @(posedge clk);
        #1;
        n_fv += int'(frame_valid);
        n_sv += int'(status_valid);
        n_pv += int'(pcm_valid);
        n_err += int'(sync_error);
    endtask

    task automatic frame(input frame_t fr, input int from, input int to, input int sync_len);
        logic [95:0] v;
        v = fr;
        for (int i = from; i < to; i++)
            step(i < sync_len, i < 96 ? v[95-i] : 1'($urandom));
    endtask

    task automatic clr();
        n_fv = 0; n_sv = 0; n_pv = 0; n_err = 0;
    endtask

    task automatic chk_outs(input string nm);
        chk({nm, "_tag"}, 32'(tag), 32'(m.tag));
        chk({nm, "_addr"}, 32'(status_addr), 32'(m.sa));
        chk({nm, "_data"}, 32'(status_data), 32'(m.sd));
        chk({nm, "_pcml"}, 32'(pcm_l), 32'(m.pl));
        chk({nm, "_pcmr"}, 32'(pcm_r), 32'(m.pr));
        chk({nm, "_ready"}, 32'(codec_ready), 32'(m.tag[15]));
    endtask

    task automatic chk_counts(input string nm, input int fv, input int sv, input int pv, input int er);
        chk({nm, "_fv_cnt"}, n_fv, fv);
        chk({nm, "_sv_cnt"}, n_sv, sv);
        chk({nm, "_pv_cnt"}, n_pv, pv);
        chk({nm, "_err_cnt"}, n_err, er);
    endtask

    task automatic chk_zero(input string nm);
        m = '0;
        chk_outs(nm);
        chk({nm, "_locked"}, 32'(locked), 0);
        chk({nm, "_syncerr"}, 32'(sync_error), 0);
        chk({nm, "_strobes"}, {29'd0, frame_valid, status_valid, pcm_valid}, 0);
    endtask

    task automatic lock_up(input string nm);
        frame_t a;
        clr();
        repeat (2) frame(rnd_frame(5'($urandom)), 0, 256, 16);
        chk({nm, "_prelock"}, 32'(locked), 0);
        chk_counts({nm, "_prelock"}, 0, 0, 0, 0);
        a = rnd_frame(5'($urandom));
        frame(a, 0, 1, 16);
        chk({nm, "_lock3"}, 32'(locked), 1);
        frame(a, 1, 256, 16);
    endtask

    task automatic settle(input string nm);
        frame_t a;
        a = rnd_frame(5'b11111);
        clr();
        frame(a, 0, 256, 16);
        m = apply(m, a);
        chk_outs(nm);
        chk_counts(nm, 1, 1, 1, 0);
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0);
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0);
        lock_up("init");
        settle("settle0");

        f = '{tag: 16'hF800, s1: 20'h26000, s2: 20'h0000F, s3: 20'h12345, s4: 20'hABCDE};
        frame(f, 0, 96, 16);
        chk("fv_at_bit95", 32'(frame_valid), 0);
        frame(f, 96, 97, 16);
        m = apply(m, f);
        chk_outs("f800");
        chk("f800_fv", 32'(frame_valid), 1);
        chk("f800_sv", 32'(status_valid), 1);
        chk("f800_pv", 32'(pcm_valid), 1);
        clr();
        frame(f, 97, 256, 16);
        chk_counts("f800_after", 0, 0, 0, 0);

        f = rnd_frame(5'b10010);
        clr();
        frame(f, 0, 256, 16);
        m = apply(m, f);
        chk_outs("t9000");
        chk_counts("t9000", 1, 0, 1, 0);

        for (int k = 0; k < 6; k++) begin
            f = rnd_frame(5'($urandom));
            clr();
            frame(f, 0, 256, 16);
            m = apply(m, f);
            chk_outs("rand");
            chk_counts("rand", 1, int'(f.tag[14] & f.tag[13]), int'(f.tag[12] | f.tag[11]), 0);
        end

        clr();
        f = rnd_frame(5'b11111);
        frame(f, 0, 40, 16);
        g = rnd_frame(5'($urandom));
        frame(g, 0, 1, 16);
        chk("mis40_err", 32'(sync_error), 1);
        chk("mis40_locked", 32'(locked), 0);
        frame(g, 1, 256, 16);
        frame(rnd_frame(5'($urandom)), 0, 256, 16);
        chk_counts("mis40", 0, 0, 0, 1);
        chk_outs("mis40_hold");
        f = rnd_frame(5'($urandom));
        frame(f, 0, 1, 16);
        chk("relock", 32'(locked), 1);
        frame(f, 1, 256, 16);
        settle("settle1");

        clr();
        f = rnd_frame(5'($urandom));
        frame(f, 0, 1, 0);
        chk("nosync_err", 32'(sync_error), 1);
        chk("nosync_locked", 32'(locked), 0);
        frame(f, 1, 256, 0);
        chk("nosync_hunt", 32'(locked), 0);
        chk_counts("nosync", 0, 0, 0, 1);

        lock_up("hunt");
        settle("settle2");
        clr();
        f = rnd_frame(5'b11111);
        frame(f, 0, 60, 16);
        rst = 1'b1;
        step(1'b0, 1'b1);
        chk_zero("midrst");
        step(1'b0, 1'b0);
        rst = 1'b0;
        chk_counts("midrst", 0, 0, 0, 0);
        lock_up("afterrst");
        settle("settle3");

        clr();
        f = rnd_frame(5'b11111);
        frame(f, 0, 95, 16);
        g = rnd_frame(5'($urandom));
        frame(g, 0, 1, 16);
        chk("rise95_err", 32'(sync_error), 1);
        chk("rise95_locked", 32'(locked), 0);
        frame(g, 1, 256, 16);
        chk_counts("rise95", 0, 0, 0, 1);
        chk_outs("rise95_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
